// File: rtl/cache_msi_ctrl.sv
// Four-line direct-mapped MSI cache controller: serves CPU reads/writes,
// broadcasts bus ops to peer caches, answers peer snoops and drives the shared memory port.
module cache_msi_ctrl #(
  parameter int         NLINES   = 4,
  parameter logic [1:0] CACHE_ID = 2'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_wr,
  input  logic [3:0] cpu_addr,
  input  logic [3:0] cpu_wdata,
  output logic       cpu_ready,
  output logic [3:0] cpu_rdata,
  output logic       bus_valid,
  output logic [1:0] bus_op,
  output logic [3:0] bus_addr,
  output logic [1:0] bus_id,
  input  logic       snoop_valid,
  input  logic [1:0] snoop_op,
  input  logic [3:0] snoop_addr,
  output logic       snoop_ack,
  output logic [3:0] mem_addr,
  output logic [3:0] mem_data,
  output logic       mem_wren,
  input  logic [7:0] mem_q,
  output logic       err
);

  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_RDX  = 2'b10;
  localparam logic [1:0] OP_UPGR = 2'b11;

  typedef enum logic [2:0] {IDLE, WB, MEM_RD, FILL, UPGR, SNP_WB, RESP} state_t;
  typedef enum logic [1:0] {LINE_I, LINE_S, LINE_M} msi_t;

  state_t     state, state_n;
  msi_t       line_st   [NLINES];
  logic [1:0] line_tag  [NLINES];
  logic [3:0] line_data [NLINES];

  logic [3:0] req_addr, req_wdata;
  logic       req_wr;
  logic [1:0] snp_idx;
  logic       snp_inval;

  logic       ready_n, bus_valid_n, ack_n, wren_n, err_n;
  logic [3:0] rdata_n, bus_addr_n, mem_addr_n, mem_data_n;
  logic [1:0] bus_op_n, bus_id_n;
  logic       latch_req, latch_snp;

  logic       line_we;
  logic [1:0] line_idx;
  msi_t       line_st_n;
  logic [1:0] line_tag_n;
  logic [3:0] line_data_n;

  logic [1:0] cpu_idx, snp_idx_c;
  logic       cpu_hit, snp_hit;

  assign cpu_idx   = cpu_addr[1:0];
  assign snp_idx_c = snoop_addr[1:0];
  assign cpu_hit   = (line_st[cpu_idx] != LINE_I) && (line_tag[cpu_idx] == cpu_addr[3:2]);
  assign snp_hit   = (line_st[snp_idx_c] != LINE_I) && (line_tag[snp_idx_c] == snoop_addr[3:2]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state, next-output and single-line update decode; line changes commit only at the
  // final step of an operation so a reset in mid-flight leaves no partial update behind.
  always_comb begin
    state_n     = state;
    ready_n     = 1'b0;
    rdata_n     = cpu_rdata;
    bus_valid_n = 1'b0;
    bus_op_n    = bus_op;
    bus_addr_n  = bus_addr;
    bus_id_n    = bus_id;
    ack_n       = 1'b0;
    mem_addr_n  = mem_addr;
    mem_data_n  = mem_data;
    wren_n      = 1'b0;
    err_n       = err;
    latch_req   = 1'b0;
    latch_snp   = 1'b0;
    line_we     = 1'b0;
    line_idx    = req_addr[1:0];
    line_st_n   = LINE_I;
    line_tag_n  = req_addr[3:2];
    line_data_n = req_wdata;

    case (state)
      IDLE: begin
        if (snoop_valid) begin
          latch_snp = 1'b1;
          if (snp_hit && line_st[snp_idx_c] == LINE_M) begin
            state_n    = SNP_WB;
            wren_n     = 1'b1;
            mem_addr_n = {line_tag[snp_idx_c], snp_idx_c};
            mem_data_n = line_data[snp_idx_c];
          end else begin
            state_n = RESP;
            ack_n   = 1'b1;
            if (snp_hit && snoop_op != OP_RD) begin
              line_we     = 1'b1;
              line_idx    = snp_idx_c;
              line_st_n   = LINE_I;
              line_tag_n  = line_tag[snp_idx_c];
              line_data_n = line_data[snp_idx_c];
            end
          end
        end else if (cpu_req) begin
          latch_req = 1'b1;
          if (cpu_hit && !cpu_wr) begin
            state_n = RESP;
            ready_n = 1'b1;
            rdata_n = line_data[cpu_idx];
          end else if (cpu_hit && line_st[cpu_idx] == LINE_M) begin
            state_n     = RESP;
            ready_n     = 1'b1;
            line_we     = 1'b1;
            line_idx    = cpu_idx;
            line_st_n   = LINE_M;
            line_tag_n  = cpu_addr[3:2];
            line_data_n = cpu_wdata;
          end else if (cpu_hit) begin
            state_n     = UPGR;
            bus_valid_n = 1'b1;
            bus_op_n    = OP_UPGR;
            bus_addr_n  = cpu_addr;
            bus_id_n    = CACHE_ID;
          end else if (line_st[cpu_idx] == LINE_M) begin
            state_n    = WB;
            wren_n     = 1'b1;
            mem_addr_n = {line_tag[cpu_idx], cpu_idx};
            mem_data_n = line_data[cpu_idx];
          end else begin
            state_n     = MEM_RD;
            mem_addr_n  = cpu_addr;
            bus_valid_n = 1'b1;
            bus_op_n    = cpu_wr ? OP_RDX : OP_RD;
            bus_addr_n  = cpu_addr;
            bus_id_n    = CACHE_ID;
          end
        end
      end
      WB: begin
        state_n     = MEM_RD;
        mem_addr_n  = req_addr;
        bus_valid_n = 1'b1;
        bus_op_n    = req_wr ? OP_RDX : OP_RD;
        bus_addr_n  = req_addr;
        bus_id_n    = CACHE_ID;
      end
      MEM_RD: state_n = FILL;
      FILL: begin
        state_n     = RESP;
        ready_n     = 1'b1;
        line_we     = 1'b1;
        line_st_n   = req_wr ? LINE_M : LINE_S;
        line_data_n = req_wr ? req_wdata : mem_q[3:0];
        rdata_n     = req_wr ? req_wdata : mem_q[3:0];
        if (mem_q[7:4] != req_addr) err_n = 1'b1;
      end
      UPGR: begin
        state_n   = RESP;
        ready_n   = 1'b1;
        line_we   = 1'b1;
        line_st_n = LINE_M;
      end
      SNP_WB: begin
        state_n     = RESP;
        ack_n       = 1'b1;
        line_we     = 1'b1;
        line_idx    = snp_idx;
        line_st_n   = snp_inval ? LINE_I : LINE_S;
        line_tag_n  = line_tag[snp_idx];
        line_data_n = line_data[snp_idx];
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      bus_valid <= 1'b0;
      bus_op    <= '0;
      bus_addr  <= '0;
      bus_id    <= '0;
      snoop_ack <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_wren  <= 1'b0;
      err       <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wr    <= 1'b0;
      snp_idx   <= '0;
      snp_inval <= 1'b0;
    end else begin
      cpu_ready <= ready_n;
      cpu_rdata <= rdata_n;
      bus_valid <= bus_valid_n;
      bus_op    <= bus_op_n;
      bus_addr  <= bus_addr_n;
      bus_id    <= bus_id_n;
      snoop_ack <= ack_n;
      mem_addr  <= mem_addr_n;
      mem_data  <= mem_data_n;
      mem_wren  <= wren_n;
      err       <= err_n;
      if (latch_req) begin
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
        req_wr    <= cpu_wr;
      end
      if (latch_snp) begin
        snp_idx   <= snp_idx_c;
        snp_inval <= (snoop_op != OP_RD);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NLINES; i++) begin
        line_st[i]   <= LINE_I;
        line_tag[i]  <= '0;
        line_data[i] <= '0;
      end
    end else if (line_we) begin
      line_st[line_idx]   <= line_st_n;
      line_tag[line_idx]  <= line_tag_n;
      line_data[line_idx] <= line_data_n;
    end
  end

endmodule

// File: tb/tb_cache_msi_ctrl.sv
// Directed self-checking bench for cache_msi_ctrl with a one-cycle-latency memory model
// that can corrupt the returned address field on demand.
module tb_cache_msi_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [3:0] cpu_addr = '0, cpu_wdata = '0;
  logic       cpu_ready;
  logic [3:0] cpu_rdata;
  logic       bus_valid;
  logic [1:0] bus_op, bus_id;
  logic [3:0] bus_addr;
  logic       snoop_valid = 1'b0;
  logic [1:0] snoop_op = '0;
  logic [3:0] snoop_addr = '0;
  logic       snoop_ack;
  logic [3:0] mem_addr, mem_data;
  logic       mem_wren;
  logic [7:0] mem_q = '0;
  logic       err;

  logic [3:0] mem [16];
  logic       corrupt = 1'b0;

  int check_count = 0;
  int error_count = 0;

  int         cpu_lat, snp_lat, bus_cnt, wren_cnt;
  logic [1:0] seen_op, seen_id;
  logic [3:0] seen_baddr, seen_waddr, seen_wdata, seen_rdata;
  int         bus_cyc, wren_cyc;

  cache_msi_ctrl dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr), .bus_id(bus_id),
    .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr), .snoop_ack(snoop_ack),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
    .err(err)
  );

  always #5 clock = ~clock;

  // Memory: writes land at the edge, reads return {addr, data} one cycle after mem_addr.
  always @(posedge clock) begin
    if (mem_wren) mem[mem_addr] <= mem_data;
    mem_q <= {(corrupt ? ~mem_addr : mem_addr), mem[mem_addr]};
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives an optional CPU request and/or snoop in the same cycle, then logs latencies and
  // the first bus broadcast / memory write seen, with cycle k meaning T+k.
  task automatic applyStimulus(input logic do_cpu, input logic wr, input logic [3:0] addr,
                               input logic [3:0] wdata, input logic do_snp,
                               input logic [1:0] op, input logic [3:0] saddr);
    logic cpu_done, snp_done;
    @(negedge clock);
    cpu_req = do_cpu; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    snoop_valid = do_snp; snoop_op = op; snoop_addr = saddr;
    cpu_lat = 0; snp_lat = 0; bus_cnt = 0; wren_cnt = 0; bus_cyc = 0; wren_cyc = 0;
    seen_op = '0; seen_id = '1; seen_baddr = '0; seen_waddr = '0; seen_wdata = '0; seen_rdata = '0;
    cpu_done = !do_cpu;
    snp_done = !do_snp;
    for (int k = 1; k <= 20 && !(cpu_done && snp_done); k++) begin
      @(negedge clock);
      if (bus_valid) begin
        bus_cnt++;
        if (bus_cnt == 1) begin
          bus_cyc = k; seen_op = bus_op; seen_baddr = bus_addr; seen_id = bus_id;
        end
      end
      if (mem_wren) begin
        wren_cnt++;
        if (wren_cnt == 1) begin
          wren_cyc = k; seen_waddr = mem_addr; seen_wdata = mem_data;
        end
      end
      if (cpu_ready && !cpu_done) begin
        cpu_done = 1'b1; cpu_lat = k; seen_rdata = cpu_rdata; cpu_req = 1'b0;
      end
      if (snoop_ack && !snp_done) begin
        snp_done = 1'b1; snp_lat = k; snoop_valid = 1'b0;
      end
    end
    if (!(cpu_done && snp_done)) checkOutput("timeout", 8'd0, 8'd1);
    cpu_req = 1'b0;
    snoop_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkOutput("rst_ready", {7'd0, cpu_ready}, 8'd0);
    checkOutput("rst_err", {7'd0, err}, 8'd0);

    // Reset while a read miss to 0x3 is on the bus.
    @(negedge clock);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 4'h3;
    @(negedge clock);
    checkOutput("inflight_bus", {7'd0, bus_valid}, 8'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort_bus", {7'd0, bus_valid}, 8'd0);
    checkOutput("abort_memaddr", {4'd0, mem_addr}, 8'd0);
    checkOutput("abort_wren", {7'd0, mem_wren}, 8'd0);
    checkOutput("abort_busop", {6'd0, bus_op}, 8'd0);
    cpu_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // Read miss 0x5, then repeat as a hit.
    applyStimulus(1, 0, 4'h5, 4'h0, 0, 2'b00, 4'h0);
    checkOutput("rdmiss_lat", 8'(cpu_lat), 8'd3);
    checkOutput("rdmiss_data", {4'd0, seen_rdata}, 8'h05);
    checkOutput("rdmiss_buscyc", 8'(bus_cyc), 8'd1);
    checkOutput("rdmiss_op", {6'd0, seen_op}, 8'h01);
    checkOutput("rdmiss_baddr", {4'd0, seen_baddr}, 8'h05);
    checkOutput("rdmiss_id", {6'd0, seen_id}, 8'h00);
    checkOutput("rdmiss_wren", 8'(wren_cnt), 8'd0);
    applyStimulus(1, 0, 4'h5, 4'h0, 0, 2'b00, 4'h0);
    checkOutput("rdhit_lat", 8'(cpu_lat), 8'd1);
    checkOutput("rdhit_data", {4'd0, seen_rdata}, 8'h05);
    checkOutput("rdhit_bus", 8'(bus_cnt), 8'd0);
    checkOutput("rdhit_wren", 8'(wren_cnt), 8'd0);

    // Write hit on S upgrades to M.
    applyStimulus(1, 1, 4'h5, 4'hA, 0, 2'b00, 4'h0);
    checkOutput("upgr_lat", 8'(cpu_lat), 8'd2);
    checkOutput("upgr_buscyc", 8'(bus_cyc), 8'd1);
    checkOutput("upgr_op", {6'd0, seen_op}, 8'h03);
    checkOutput("upgr_wren", 8'(wren_cnt), 8'd0);

    // Read 0x9 evicts dirty 0x5.
    applyStimulus(1, 0, 4'h9, 4'h0, 0, 2'b00, 4'h0);
    checkOutput("wb_lat", 8'(cpu_lat), 8'd4);
    checkOutput("wb_cyc", 8'(wren_cyc), 8'd1);
    checkOutput("wb_cnt", 8'(wren_cnt), 8'd1);
    checkOutput("wb_addr", {4'd0, seen_waddr}, 8'h05);
    checkOutput("wb_data", {4'd0, seen_wdata}, 8'h0A);
    checkOutput("wb_buscyc", 8'(bus_cyc), 8'd2);
    checkOutput("wb_rdata", {4'd0, seen_rdata}, 8'h09);
    checkOutput("wb_mem5", {4'd0, mem[5]}, 8'h0A);
    checkOutput("wb_err", {7'd0, err}, 8'd0);

    // Write miss over clean victim 0x9 gives 0x5 in M with 0xC.
    applyStimulus(1, 1, 4'h5, 4'hC, 0, 2'b00, 4'h0);
    checkOutput("wrmiss_lat", 8'(cpu_lat), 8'd3);
    checkOutput("wrmiss_op", {6'd0, seen_op}, 8'h02);
    checkOutput("wrmiss_wren", 8'(wren_cnt), 8'd0);

    // Snoop BusRd on M writes back and downgrades; BusRdX on S then invalidates.
    applyStimulus(0, 0, 4'h0, 4'h0, 1, 2'b01, 4'h5);
    checkOutput("sbrd_lat", 8'(snp_lat), 8'd2);
    checkOutput("sbrd_wren", 8'(wren_cnt), 8'd1);
    checkOutput("sbrd_addr", {4'd0, seen_waddr}, 8'h05);
    checkOutput("sbrd_data", {4'd0, seen_wdata}, 8'h0C);
    checkOutput("sbrd_mem5", {4'd0, mem[5]}, 8'h0C);
    applyStimulus(0, 0, 4'h0, 4'h0, 1, 2'b10, 4'h5);
    checkOutput("srdx_lat", 8'(snp_lat), 8'd1);
    checkOutput("srdx_wren", 8'(wren_cnt), 8'd0);
    applyStimulus(1, 0, 4'h5, 4'h0, 0, 2'b00, 4'h0);
    checkOutput("postinv_lat", 8'(cpu_lat), 8'd3);
    checkOutput("postinv_data", {4'd0, seen_rdata}, 8'h0C);

    // Snoop and CPU in the same cycle: snoop first, CPU read hits after downgrade.
    applyStimulus(1, 1, 4'h5, 4'h7, 0, 2'b00, 4'h0);
    checkOutput("upgr2_lat", 8'(cpu_lat), 8'd2);
    applyStimulus(1, 0, 4'h5, 4'h0, 1, 2'b01, 4'h5);
    checkOutput("arb_snp_lat", 8'(snp_lat), 8'd2);
    checkOutput("arb_cpu_lat", 8'(cpu_lat), 8'd4);
    checkOutput("arb_rdata", {4'd0, seen_rdata}, 8'h07);
    checkOutput("arb_wdata", {4'd0, seen_wdata}, 8'h07);
    checkOutput("arb_bus", 8'(bus_cnt), 8'd0);

    // Corrupted fill address sets sticky err; only reset clears it.
    corrupt = 1'b1;
    applyStimulus(1, 0, 4'hE, 4'h0, 0, 2'b00, 4'h0);
    corrupt = 1'b0;
    checkOutput("err_lat", 8'(cpu_lat), 8'd3);
    checkOutput("err_set", {7'd0, err}, 8'd1);
    applyStimulus(1, 0, 4'h3, 4'h0, 0, 2'b00, 4'h0);
    checkOutput("err_clean_lat", 8'(cpu_lat), 8'd3);
    checkOutput("err_clean_data", {4'd0, seen_rdata}, 8'h03);
    checkOutput("err_sticky", {7'd0, err}, 8'd1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("err_cleared", {7'd0, err}, 8'd0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1, 0, 4'h3, 4'h0, 0, 2'b00, 4'h0);
    checkOutput("post_rst_miss", 8'(cpu_lat), 8'd3);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/cache_msi_ctrl.md
Name: cache_msi_ctrl

Overview:
- Per-processor cache controller for the snooping-coherence system. Sits directly upstream of the shared memory block and drives its addr/data/wren port.
- Holds a 4-line direct-mapped cache with 4-bit data and MSI state per line.
- Serves CPU read/write requests, broadcasts bus ops to peer caches, and answers peer snoops with write-back/downgrade/invalidate.
- Memory port contract: write takes effect at the clock edge; read data returns one cycle later on mem_q = {addr, data}.

Parameters:
- NLINES, 4, number of lines; index = addr[1:0], tag = addr[3:2] (fixed to 4 in this revision).
- CACHE_ID, 0, identifier placed on bus_id with every broadcast.

Ports:
- clock  in  1  system clock, posedge.
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  request valid; held until cpu_ready.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_addr  in  4  request address.
- cpu_wdata  in  4  write data.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  4  read data; valid with cpu_ready.
- bus_valid  out  1  one-cycle broadcast pulse.
- bus_op  out  2  01 BusRd, 10 BusRdX, 11 BusUpgr.
- bus_addr  out  4  broadcast address.
- bus_id  out  2  CACHE_ID.
- snoop_valid  in  1  peer op valid; held until snoop_ack.
- snoop_op  in  2  encoding as bus_op.
- snoop_addr  in  4  peer address.
- snoop_ack  out  1  one-cycle snoop completion pulse.
- mem_addr  out  4  memory address.
- mem_data  out  4  memory write data.
- mem_wren  out  1  memory write enable.
- mem_q  in  8  memory return {addr, data}.
- err  out  1  sticky: mem_q[7:4] mismatch on fill.

Behaviour:
- Reset (async):
  - All lines go to I; tags and data go to 0.
  - FSM goes to IDLE.
  - All outputs go to 0, including err.
  - Reset mid-operation aborts the operation: mem_wren drops immediately and no partial line update is kept.
- FSM states: IDLE, WB, MEM_RD, FILL, UPGR, SNP_WB, RESP. All outputs are registered.
- IDLE arbitration:
  - snoop_valid has priority over cpu_req in the same cycle.
  - The CPU request waits; it is not dropped.
- CPU acceptance: a request is accepted at cycle T when the FSM is in IDLE and cpu_req=1. Lookup is combinational on cpu_addr.
- Read hit (S or M): cpu_rdata = line data, cpu_ready at T+1. No bus or memory activity.
- Write hit, M: line data <= cpu_wdata, cpu_ready at T+1.
- Write hit, S:
  - UPGR at T+1: bus_valid=1, bus_op=11, line -> M with data written.
  - cpu_ready at T+2.
- Miss, victim I or S:
  - T+1 MEM_RD: mem_addr=cpu_addr, mem_wren=0, bus_valid=1, bus_op=01 (read) or 10 (write).
  - T+2 FILL: capture mem_q[3:0]. Read miss -> S with memory data. Write miss -> M with cpu_wdata.
  - cpu_ready at T+3.
  - If mem_q[7:4] != cpu_addr: set err, still complete.
- Miss, victim M:
  - T+1 WB: mem_wren=1, mem_addr={victim tag, index}, mem_data = victim data.
  - Then MEM_RD/FILL as above; cpu_ready at T+4.
- Victim S is discarded silently.
- Snoop on tag match with line valid:
  - BusRd on M: SNP_WB writes the line to memory, line -> S, snoop_ack 2 cycles after acceptance.
  - BusRd on S: no change, snoop_ack at +1.
  - BusRdX or BusUpgr on M: write-back, then I, snoop_ack at +2.
  - BusRdX or BusUpgr on S: -> I, snoop_ack at +1.
- Snoop on miss or line I: snoop_ack at +1, no change.
- Snoops arriving while the FSM is not in IDLE are held by the sender and serviced on return to IDLE.
- mem_wren is high for exactly one cycle per write-back. It is never high in MEM_RD/FILL/IDLE/RESP.
- A new request sampled in the cycle of cpu_ready is ignored; acceptance resumes the cycle after.

Test Plan:
- Reset with a random request in flight -> all lines I, outputs 0, IDLE; a subsequent read of 0x5 misses.
- Bench memory preloaded m[5]=4'h5. Read 0x5 at T -> bus_op=01 pulse at T+1, cpu_rdata=4'h5 with cpu_ready at T+3. Repeat read -> hit, cpu_ready at T+1, no mem/bus activity.
- Write 0x5 data 4'hA after the read fill (S) -> bus_op=11 at T+1, cpu_ready at T+2, line M. Then read 0x9 (same index) -> WB cycle mem_wren=1, mem_addr=0x5, mem_data=4'hA; memory m[5]=4'hA; cpu_rdata=4'h9 at T+4.
- Line 0x5 in M=4'hA, snoop BusRd 0x5 -> mem write 0x5/4'hA, line S, snoop_ack at +2. Then snoop BusRdX 0x5 -> line I, snoop_ack at +1, no mem_wren.
- snoop_valid and cpu_req asserted in the same IDLE cycle -> snoop serviced first; CPU completes after snoop_ack with correct latency.
- Bench memory model returns a corrupted mem_q[7:4] on a fill -> err=1 and stays 1 until reset; cpu_ready still issued.
